spmm_row_addrgen: RTL and testbench



---
 rtl/spmm_row_addrgen_if.sv | 22 ++
 rtl/spmm_row_addrgen.sv | 150 +++++++++++++++
 tb/tb_spmm_row_addrgen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spmm_row_addrgen_if.sv
// Valid/ready stream bundle shared by the index sink
// and the address source of the row address generator.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/spmm_row_addrgen.sv
// Turns a stream of CSR column indices into word addresses
// of the matching dense B rows for the TCDM source streamer.
module spmm_row_addrgen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] row_stride_i,
  input  logic [CNT_WIDTH-1:0]  words_per_row_i,
  input  logic [CNT_WIDTH-1:0]  nnz_i,
  hwpe_stream_intf_stream.sink   idx_i,
  hwpe_stream_intf_stream.source addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned PW = ADDR_WIDTH + IDX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [CNT_WIDTH-1:0]  nnz_q, nnz_d;
  logic [CNT_WIDTH-1:0]  nnz_cnt_q, nnz_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [PW-1:0]         prod;
  logic [ADDR_WIDTH-1:0] woff;
  logic                  addr_hs;
  logic                  unused_bits;

  assign unused_bits = ^{idx_i.data, idx_i.strb};

  // Full-width product so high index/stride bits are not lost
  // before the final mod-2^ADDR_WIDTH truncation.
  assign prod = PW'(idx_i.data[IDX_WIDTH-1:0]) * PW'(stride_q);
  assign woff = ADDR_WIDTH'(word_cnt_q) * ADDR_WIDTH'(WORD_BYTES);

  assign addr_hs     = valid_q & addr_o.ready;
  assign idx_i.ready = (state_q == FETCH);
  assign addr_o.valid = valid_q;
  assign addr_o.data  = row_base_q + woff;
  assign addr_o.strb  = '1;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    stride_d   = stride_q;
    words_d    = words_q;
    nnz_d      = nnz_q;
    nnz_cnt_d  = nnz_cnt_q;
    word_cnt_d = word_cnt_q;
    row_base_d = row_base_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i;
          stride_d   = row_stride_i;
          words_d    = words_per_row_i;
          nnz_d      = nnz_i;
          nnz_cnt_d  = '0;
          word_cnt_d = '0;
          if (nnz_i == '0 || words_per_row_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (idx_i.valid) begin
          row_base_d = base_q + prod[ADDR_WIDTH-1:0];
          valid_d    = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (addr_hs) begin
          if (word_cnt_q == words_q - 1'b1) begin
            word_cnt_d = '0;
            nnz_cnt_d  = nnz_cnt_q + 1'b1;
            valid_d    = 1'b0;
            if (nnz_cnt_q == nnz_q - 1'b1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset and soft clear both abandon the job.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      words_q    <= '0;
      nnz_q      <= '0;
      nnz_cnt_q  <= '0;
      word_cnt_q <= '0;
      row_base_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      words_q    <= words_d;
      nnz_q      <= nnz_d;
      nnz_cnt_q  <= nnz_cnt_d;
      word_cnt_q <= word_cnt_d;
      row_base_q <= row_base_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spmm_row_addrgen.sv
// Directed table-driven bench for spmm_row_addrgen
// plus backpressure, clear and restart sequences.
module tb_spmm_row_addrgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] base;
  logic [31:0] stride;
  logic [15:0] words;
  logic [15:0] nnz;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) idx_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) addr_s ();

  spmm_row_addrgen dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .base_addr_i     (base),
    .row_stride_i    (stride),
    .words_per_row_i (words),
    .nnz_i           (nnz),
    .idx_i           (idx_s),
    .addr_o          (addr_s),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [15:0]      words;
    logic [15:0]      nnz;
    logic [2:0][15:0] idx;
    logic [7:0][31:0] exp;
    logic [7:0]       exp_n;
    logic [7:0]       exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // bp: toggle addr ready; inj: cycle to inject a second start (0=none)
  task automatic run_job(input vec_t v, input bit bp, input int inj);
    logic [31:0] got [$];
    int   cyc;
    int   ptr;
    int   acc;
    int   ndone;
    int   done_cyc;
    bit   fin;
    logic pv, pr;
    logic [31:0] pd;
    got.delete();
    ptr = 0; acc = 0; ndone = 0; done_cyc = -1; fin = 0;
    pv = 0; pr = 0; pd = '0;
    base = v.base; stride = v.stride;
    words = v.words; nnz = v.nnz;
    start = 1'b1;
    idx_s.valid = 1'b1;
    idx_s.data = {16'hABCD, v.idx[0]};
    addr_s.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 300) begin
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; base = 32'h0; nnz = 16'd1; words = 16'd1;
      end else begin
        start = 1'b0;
      end
      addr_s.ready = bp ? logic'(cyc % 2) : 1'b1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (done_cyc >= 0 && !busy) begin
        fin = 1;
      end
      if (pv && !pr)
        chk("hold_data", addr_s.data, pd);
      if (addr_s.valid)
        chk("idx_ready_in_emit", {31'b0, idx_s.ready}, 32'd0);
      if (addr_s.valid && addr_s.ready) got.push_back(addr_s.data);
      pv = addr_s.valid; pr = addr_s.ready; pd = addr_s.data;
      if (idx_s.ready && idx_s.valid) begin
        acc++;
        ptr++;
      end
      @(negedge clk);
      if (ptr < 3) idx_s.data = {16'h5A5A, v.idx[ptr]};
      cyc++;
    end
    start = 1'b0;
    idx_s.valid = 1'b0;
    chk("timeout", {31'b0, fin}, 32'd1);
    chk("addr_count", got.size(), 32'(v.exp_n));
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("addr%0d", i), got[i], v.exp[i]);
    chk("done_pulses", ndone, 32'd1);
    chk("idx_accepts", acc, (v.words == 0) ? 32'd0 : 32'(v.nnz));
    if (!bp) chk("done_cycle", done_cyc, 32'(v.exp_cyc));
  endtask

  initial begin
    vecs[0] = '{32'h1000, 32'h40, 16'd4, 16'd2, {16'd0, 16'd0, 16'd3},
      {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
      8'd8, 8'd11};
    vecs[0].exp = {32'h100C, 32'h1008, 32'h1004, 32'h1000,
                   32'h10CC, 32'h10C8, 32'h10C4, 32'h10C0};
    vecs[1] = '{32'hFFFF_FFF8, 32'h10, 16'd2, 16'd1,
      {16'd0, 16'd0, 16'd1}, {192'h0, 32'hC, 32'h8}, 8'd2, 8'd4};
    vecs[2] = '{32'h0, 32'h40, 16'd4, 16'd0, 48'h0, 256'h0, 8'd0, 8'd1};
    vecs[3] = '{32'h0, 32'h40, 16'd0, 16'd3, 48'h0, 256'h0, 8'd0, 8'd1};
    vecs[4] = '{32'h2000, 32'h100, 16'd1, 16'd3,
      {16'd5, 16'hFFFF, 16'd2},
      {160'h0, 32'h2500, 32'h0100_1F00, 32'h2200}, 8'd3, 8'd7};
    vecs[5] = '{32'h0, 32'h1000_0001, 16'd1, 16'd1,
      {16'd0, 16'd0, 16'h10}, {224'h0, 32'h10}, 8'd1, 8'd3};

    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    base = '0; stride = '0; words = '0; nnz = '0;
    idx_s.valid = 1'b0; idx_s.data = '0; idx_s.strb = '1;
    addr_s.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, addr_s.valid}, 32'd0);
    chk("rst_data", addr_s.data, 32'd0);
    chk("rst_idx_ready", {31'b0, idx_s.ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i], 1'b0, 0);
      @(negedge clk);
    end

    run_job(vecs[0], 1'b1, 0);
    @(negedge clk);

    run_job(vecs[0], 1'b0, 3);
    @(negedge clk);

    // Clear during EMIT of the second of three rows
    base = 32'h1000; stride = 32'h40; words = 16'd4; nnz = 16'd3;
    start = 1'b1; idx_s.valid = 1'b1; idx_s.data = 32'd1;
    addr_s.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_clear_valid", {31'b0, addr_s.valid}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idx_s.valid = 1'b0;
    chk("clr_valid", {31'b0, addr_s.valid}, 32'd0);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("clr_no_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    run_job(vecs[0], 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
